// File: rtl/tpu_layer_sequencer.sv
// tpu_layer_sequencer
//
// Runs an N-layer fully-connected inference chain one engine at a time. The
// granted engine gets a one-cycle reset pulse, then runs until it raises its
// done level. While it runs, it owns the shared weight ROM address port and
// the shared multiply-add operand buses. After the last layer finishes, the
// argmax index is latched and done is raised. A watchdog aborts any layer
// that stays in RUN for TIMEOUT cycles without finishing.
//
// Ports:
//   clk         rising-edge clock
//   iRst_n      synchronous active-low reset; takes priority over ena
//   ena         global enable; low freezes all state and registered outputs
//   start       begin inference; accepted in IDLE, DONE and ERROR only
//   layer_done  per-engine done level; only the granted engine's bit is used
//   addr_in     per-engine ROM address, engine k at [k*ADDR_W +: ADDR_W]
//   opr1_in     per-engine operand 1, engine k at [k*OPR_W +: OPR_W]
//   opr2_in     per-engine operand 2, engine k at [k*OPR_W +: OPR_W]
//   result_in   argmax index from the last layer
//   layer_ena   one-hot engine enable
//   layer_rstn  per-engine synchronous reset, active low
//   rom_addr    address of the granted engine, 0 when no engine is enabled
//   opr1_out    operand 1 of the granted engine, 0 when no engine is enabled
//   opr2_out    operand 2 of the granted engine, 0 when no engine is enabled
//   cur_layer   index of the granted engine
//   num_out     latched result (all ones after a watchdog abort)
//   busy        high while an engine is being reset or run
//   done        high once the chain has finished or aborted
//   error       high after a watchdog abort

module tpu_layer_sequencer #(
    parameter int NUM_LAYERS = 2,
    parameter int ADDR_W     = 11,
    parameter int OPR_W      = 1024,
    parameter int IDX_W      = 4,
    parameter int TIMEOUT    = 65535
) (
    input  logic                         clk,
    input  logic                         iRst_n,
    input  logic                         ena,
    input  logic                         start,
    input  logic [NUM_LAYERS-1:0]        layer_done,
    input  logic [NUM_LAYERS*ADDR_W-1:0] addr_in,
    input  logic [NUM_LAYERS*OPR_W-1:0]  opr1_in,
    input  logic [NUM_LAYERS*OPR_W-1:0]  opr2_in,
    input  logic [IDX_W-1:0]             result_in,
    output logic [NUM_LAYERS-1:0]        layer_ena,
    output logic [NUM_LAYERS-1:0]        layer_rstn,
    output logic [ADDR_W-1:0]            rom_addr,
    output logic [OPR_W-1:0]             opr1_out,
    output logic [OPR_W-1:0]             opr2_out,
    output logic [2:0]                   cur_layer,
    output logic [IDX_W-1:0]             num_out,
    output logic                         busy,
    output logic                         done,
    output logic                         error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RST,
        S_RUN,
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [2:0]  LAST_LAYER = 3'(NUM_LAYERS - 1);
    localparam logic [15:0] WD_LAST    = 16'(TIMEOUT - 1);

    state_t      state;
    logic [15:0] watchdog;
    logic        sel_done;

    function automatic logic [NUM_LAYERS-1:0] onehot(input logic [2:0] idx);
        logic [NUM_LAYERS-1:0] v;
        v = '0;
        for (int k = 0; k < NUM_LAYERS; k++) begin
            if (idx == 3'(k)) begin
                v[k] = 1'b1;
            end
        end
        return v;
    endfunction

    // Only the granted engine's done bit matters; stray bits are dropped here.
    always_comb begin
        sel_done = 1'b0;
        for (int k = 0; k < NUM_LAYERS; k++) begin
            if (cur_layer == 3'(k)) begin
                sel_done = layer_done[k];
            end
        end
    end

    // Shared-resource muxes. When nothing is enabled, they drive 0 so the ROM
    // and the multiply-add unit see a quiet bus.
    always_comb begin
        rom_addr = '0;
        opr1_out = '0;
        opr2_out = '0;
        if (|layer_ena) begin
            for (int k = 0; k < NUM_LAYERS; k++) begin
                if (cur_layer == 3'(k)) begin
                    rom_addr = addr_in[k*ADDR_W +: ADDR_W];
                    opr1_out = opr1_in[k*OPR_W +: OPR_W];
                    opr2_out = opr2_in[k*OPR_W +: OPR_W];
                end
            end
        end
    end

    // Sequencer FSM. All outputs are registered alongside the state. A done
    // seen on the same edge as the watchdog limit takes precedence over the
    // abort, so a layer that finishes on its very last allowed cycle counts
    // as a success.
    always_ff @(posedge clk) begin
        if (!iRst_n) begin
            state      <= S_IDLE;
            cur_layer  <= '0;
            layer_ena  <= '0;
            layer_rstn <= '1;
            num_out    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            watchdog   <= '0;
        end else if (ena) begin
            case (state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        state      <= S_RST;
                        cur_layer  <= '0;
                        layer_ena  <= onehot(3'd0);
                        layer_rstn <= ~onehot(3'd0);
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        error      <= 1'b0;
                        watchdog   <= '0;
                    end
                end
                S_RST: begin
                    state      <= S_RUN;
                    layer_rstn <= '1;
                    watchdog   <= '0;
                end
                S_RUN: begin
                    if (sel_done) begin
                        if (cur_layer == LAST_LAYER) begin
                            state     <= S_DONE;
                            num_out   <= result_in;
                            layer_ena <= '0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            state      <= S_RST;
                            cur_layer  <= cur_layer + 3'd1;
                            layer_ena  <= onehot(cur_layer + 3'd1);
                            layer_rstn <= ~onehot(cur_layer + 3'd1);
                            watchdog   <= '0;
                        end
                    end else if (watchdog == WD_LAST) begin
                        state     <= S_ERROR;
                        num_out   <= '1;
                        layer_ena <= '0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        error     <= 1'b1;
                    end else begin
                        watchdog <= watchdog + 16'd1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/tpu_layer_sequencer.md
Name: tpu_layer_sequencer

Overview:
Parametrised control sequencer for an N-layer fully-connected inference chain. It runs the layer engines one at a time and gives exactly one of them the shared weight ROM address port and the shared multiply-add unit. It latches the final argmax index and reports completion with a start/done handshake. A watchdog aborts any layer that never raises its done.

Parameters:
NUM_LAYERS, 2, number of sequenced layer engines (1..8)
ADDR_W, 11, weight ROM address width per engine
OPR_W, 1024, width of one multiply-add operand bus per engine
IDX_W, 4, width of the result index
TIMEOUT, 65535, max cycles a layer may stay in RUN before abort (fits 16-bit counter)

Ports:
clk  in  1  clock, rising edge
iRst_n  in  1  synchronous active-low reset
ena  in  1  global enable; low = freeze all state
start  in  1  begin inference; sampled in IDLE, DONE and ERROR
layer_done  in  NUM_LAYERS  per-engine done level
addr_in  in  NUM_LAYERS*ADDR_W  per-engine ROM address, engine k at bits [k*ADDR_W +: ADDR_W]
opr1_in  in  NUM_LAYERS*OPR_W  per-engine operand 1
opr2_in  in  NUM_LAYERS*OPR_W  per-engine operand 2
result_in  in  IDX_W  argmax index from the last layer's output
layer_ena  out  NUM_LAYERS  one-hot engine enable
layer_rstn  out  NUM_LAYERS  per-engine synchronous reset, active low
rom_addr  out  ADDR_W  muxed address to the shared ROM
opr1_out  out  OPR_W  muxed operand 1 to the multiply-add unit
opr2_out  out  OPR_W  muxed operand 2 to the multiply-add unit
cur_layer  out  3  index of the granted engine
num_out  out  IDX_W  latched result
busy  out  1  high in RST and RUN
done  out  1  high in DONE and ERROR
error  out  1  high in ERROR

Behaviour:
- Reset (iRst_n=0 at an edge, has priority over ena): state IDLE, cur_layer=0, layer_ena=0, layer_rstn=all 1, num_out=0, busy=0, done=0, error=0, watchdog=0. Reset mid-run aborts immediately, with no partial result.
- ena=0: state, counters and all registered outputs hold. start and layer_done are ignored.
- Muxes (combinational): rom_addr, opr1_out and opr2_out select the slice of engine cur_layer while layer_ena is nonzero. They drive 0 otherwise. No tri-state.
- FSM states: IDLE, RST, RUN, DONE, ERROR.
- IDLE: start=1 -> RST with cur_layer=0.
- RST: exactly one cycle. layer_ena[cur_layer]=1 and layer_rstn[cur_layer]=0, all other bits inactive. Watchdog cleared. Next state RUN.
- RUN: layer_ena[cur_layer]=1, layer_rstn all 1, watchdog increments every enabled cycle.
  - layer_done[cur_layer]=1 and cur_layer<NUM_LAYERS-1 -> cur_layer+1 and RST. The enable moves to the next engine in the same edge, with no idle gap.
  - layer_done[cur_layer]=1 on the last layer -> num_out<=result_in, layer_ena<=0, DONE.
  - If done and watchdog==TIMEOUT-1 occur together, done wins.
  - Otherwise, watchdog==TIMEOUT-1 -> ERROR.
  - layer_done bits from non-granted engines are ignored.
- Latency: start seen at edge t gives RST in cycle t+1 and RUN from t+2. The last layer's done seen at edge u gives done=1 and a valid num_out from u+1.
- DONE: done held high until start=1, which restarts directly into RST with cur_layer=0 and done=0 at the next edge.
- ERROR: error=1, done=1, num_out={IDX_W{1'b1}}, layer_ena=0. Left only by start (restart as above) or reset.
- start while busy is ignored.

Test Plan:
- NUM_LAYERS=2: reset, then start pulse. layer_done[0] rises 20 cycles after RUN, layer_done[1] 10 cycles later, result_in=7 -> layer_ena goes 01 then 10 back-to-back, each layer_rstn bit low for exactly one cycle, done=1 and num_out=7 exactly one cycle after layer_done[1].
- Mux check: addr_in={11'h155,11'h0AA} -> rom_addr=0x0AA during layer 0, 0x155 during layer 1, 0 in IDLE and DONE. Same check for opr1 and opr2.
- Watchdog, TIMEOUT=16: layer_done never asserts -> ERROR 16 cycles after RUN entry with error=1, done=1, num_out=4'hF, layer_ena=0. A later start restarts from layer 0.
- ena held low for 5 cycles during layer-1 RUN, with layer_done[1] pulsed while ena=0 -> no state change and the watchdog frozen. Completion occurs only on a layer_done seen with ena=1.
- iRst_n low mid-run of layer 1 -> next cycle all outputs at reset values and state IDLE. Also: a start pulse during RUN is ignored, and a stray layer_done[1] during layer 0 causes no advance.
- NUM_LAYERS=4: all four layers sequence in order, cur_layer counts 0 to 3, and a second start from DONE repeats the run with an identical trace.
